// File: rtl/load_use_scoreboard.sv
// Load-use hazard scoreboard: per-register load latency counters, two-source hazard check,
// memory-miss freeze and branch-flush priority, plus a saturating stall-cycle counter.
module load_use_scoreboard #(
  parameter int unsigned NREG     = 16,
  parameter int unsigned REG_W    = 4,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             id_valid_i,
  input  logic [REG_W-1:0] id_src1_i,
  input  logic [REG_W-1:0] id_src2_i,
  input  logic             id_src1_used_i,
  input  logic             id_src2_used_i,
  input  logic [REG_W-1:0] id_dst_i,
  input  logic             id_is_load_i,
  input  logic             ex_branch_taken_i,
  input  logic             mem_busy_i,
  output logic             stall_if_id_o,
  output logic             bubble_ex_o,
  output logic             flush_if_id_o,
  output logic             freeze_o,
  output logic [CNT_W-1:0] stall_cycles_o
);

  localparam int unsigned PendW = $clog2(LOAD_LAT + 1);
  typedef logic [PendW-1:0] pend_t;
  localparam pend_t LatVal = pend_t'(LOAD_LAT);

  pend_t            pend_q [NREG];
  pend_t            pend_d [NREG];
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic src1_haz, src2_haz, haz, issue, set_dst;

  always_comb begin
    src1_haz = id_src1_used_i && (pend_q[id_src1_i] != '0) &&
               !((ZERO_REG != 0) && (id_src1_i == '0));
    src2_haz = id_src2_used_i && (pend_q[id_src2_i] != '0) &&
               !((ZERO_REG != 0) && (id_src2_i == '0));
    haz      = id_valid_i && (src1_haz || src2_haz);
    issue    = id_valid_i && !mem_busy_i && !ex_branch_taken_i && !haz;
    set_dst  = issue && id_is_load_i && !((ZERO_REG != 0) && (id_dst_i == '0));
  end

  // Outputs are forced low while reset is held, even if other inputs are active.
  always_comb begin
    stall_if_id_o = 1'b0;
    bubble_ex_o   = 1'b0;
    flush_if_id_o = 1'b0;
    freeze_o      = 1'b0;
    if (!rst_i) begin
      if (mem_busy_i) begin
        freeze_o = 1'b1;
      end else if (ex_branch_taken_i) begin
        flush_if_id_o = 1'b1;
        bubble_ex_o   = 1'b1;
      end else if (haz) begin
        stall_if_id_o = 1'b1;
        bubble_ex_o   = 1'b1;
      end
    end
  end

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      pend_d[r] = pend_q[r];
      if (!mem_busy_i && (pend_q[r] != '0)) begin
        pend_d[r] = pend_q[r] - pend_t'(1);
      end
    end
    // A newly issued load (including WAW) overrides the decrement for its destination.
    if (set_dst) begin
      pend_d[id_dst_i] = LatVal;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (haz && !mem_busy_i && !ex_branch_taken_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int r = 0; r < NREG; r++) begin
        pend_q[r] <= '0;
      end
      cnt_q <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign stall_cycles_o = cnt_q;

endmodule

// File: tb/tb_load_use_scoreboard.sv
// Bench for load_use_scoreboard: three parameterisations share one stimulus stream and are
// checked by directed scenarios and a timestamp-based reference model under random stimulus.
module tb_load_use_scoreboard;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0, u1 = 1'b0, u2 = 1'b0, load = 1'b0, br = 1'b0, busy = 1'b0;
  logic [3:0] src1 = '0, src2 = '0, dst = '0;

  logic [2:0]  stall_o, bubble_o, flush_o, freeze_o;
  logic [15:0] cnt_a, cnt_b;
  logic [3:0]  cnt_c;
  logic [3:0]  ctl [3];
  logic [15:0] cnt_obs [3];

  int n_checks = 0;
  int n_fail   = 0;

  // Per-instance configuration: {LOAD_LAT, ZERO_REG, counter max}
  int unsigned lat  [3] = '{1, 3, 7};
  int unsigned zr   [3] = '{1, 1, 0};
  int unsigned cmax [3] = '{65535, 65535, 15};

  // Reference model: a register is free once enough unfrozen cycles have elapsed.
  longint unsigned act;
  longint unsigned avail_at [3][16];
  int unsigned     mcnt [3];

  always #5 clk = ~clk;

  load_use_scoreboard #(.NREG(16), .REG_W(4), .LOAD_LAT(1), .ZERO_REG(1), .CNT_W(16)) dut_a (
    .clk_i(clk), .rst_i(rst), .id_valid_i(valid), .id_src1_i(src1), .id_src2_i(src2),
    .id_src1_used_i(u1), .id_src2_used_i(u2), .id_dst_i(dst), .id_is_load_i(load),
    .ex_branch_taken_i(br), .mem_busy_i(busy), .stall_if_id_o(stall_o[0]),
    .bubble_ex_o(bubble_o[0]), .flush_if_id_o(flush_o[0]), .freeze_o(freeze_o[0]),
    .stall_cycles_o(cnt_a)
  );

  load_use_scoreboard #(.NREG(16), .REG_W(4), .LOAD_LAT(3), .ZERO_REG(1), .CNT_W(16)) dut_b (
    .clk_i(clk), .rst_i(rst), .id_valid_i(valid), .id_src1_i(src1), .id_src2_i(src2),
    .id_src1_used_i(u1), .id_src2_used_i(u2), .id_dst_i(dst), .id_is_load_i(load),
    .ex_branch_taken_i(br), .mem_busy_i(busy), .stall_if_id_o(stall_o[1]),
    .bubble_ex_o(bubble_o[1]), .flush_if_id_o(flush_o[1]), .freeze_o(freeze_o[1]),
    .stall_cycles_o(cnt_b)
  );

  load_use_scoreboard #(.NREG(16), .REG_W(4), .LOAD_LAT(7), .ZERO_REG(0), .CNT_W(4)) dut_c (
    .clk_i(clk), .rst_i(rst), .id_valid_i(valid), .id_src1_i(src1), .id_src2_i(src2),
    .id_src1_used_i(u1), .id_src2_used_i(u2), .id_dst_i(dst), .id_is_load_i(load),
    .ex_branch_taken_i(br), .mem_busy_i(busy), .stall_if_id_o(stall_o[2]),
    .bubble_ex_o(bubble_o[2]), .flush_if_id_o(flush_o[2]), .freeze_o(freeze_o[2]),
    .stall_cycles_o(cnt_c)
  );

  // ctl packs {stall, bubble, flush, freeze}
  assign ctl[0] = {stall_o[0], bubble_o[0], flush_o[0], freeze_o[0]};
  assign ctl[1] = {stall_o[1], bubble_o[1], flush_o[1], freeze_o[1]};
  assign ctl[2] = {stall_o[2], bubble_o[2], flush_o[2], freeze_o[2]};
  assign cnt_obs[0] = cnt_a;
  assign cnt_obs[1] = cnt_b;
  assign cnt_obs[2] = {12'h000, cnt_c};

  task automatic drive(input logic v, input logic [3:0] s1, input logic us1, input logic [3:0] s2,
                       input logic us2, input logic [3:0] d, input logic ld, input logic b,
                       input logic bz);
    valid = v; src1 = s1; u1 = us1; src2 = s2; u2 = us2; dst = d; load = ld; br = b; busy = bz;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    idle();
    #2;
    rst = 1'b0;
  endtask

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      mcnt[k] = 0;
      for (int r = 0; r < 16; r++) avail_at[k][r] = 0;
    end
  endtask

  function automatic bit pending(input int k, input logic [3:0] r);
    if (zr[k] != 0 && r == 4'd0) return 1'b0;
    return act < avail_at[k][r];
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 4'd3, 1'b1, 4'd4, 1'b1, 4'd5, 1'b1, 1'b1, 1'b1);
    #1;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (ctl[k] !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_ctl[%0d]: got %b want 0000", k, ctl[k]);
      end
      n_checks++;
      if (cnt_obs[k] !== 16'd0) begin
        n_fail++;
        $display("FAIL reset_cnt[%0d]: got %0d want 0", k, cnt_obs[k]);
      end
    end
    step();
    rst = 1'b0;
    drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    #1;
    n_checks++;
    if (ctl[0] !== 4'b0001) begin
      n_fail++;
      $display("FAIL post_reset_freeze: got %b want 0001", ctl[0]);
    end
    idle();
  endtask

  task automatic test_load_use_lat1();
    do_reset();
    step();
    drive(1'b1, 4'd1, 1'b0, 4'd2, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0);  // LW R3
    #1;
    n_checks++;
    if (ctl[0] !== 4'b0000) begin
      n_fail++;
      $display("FAIL lat1_lw_c0: got %b want 0000", ctl[0]);
    end
    step();
    drive(1'b1, 4'd3, 1'b1, 4'd5, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0);  // ADD R4,R3,R5
    #1;
    n_checks++;
    if (ctl[0] !== 4'b1100) begin
      n_fail++;
      $display("FAIL lat1_stall_c1: got %b want 1100", ctl[0]);
    end
    step();
    #1;
    n_checks++;
    if (ctl[0] !== 4'b0000) begin
      n_fail++;
      $display("FAIL lat1_issue_c2: got %b want 0000", ctl[0]);
    end
    n_checks++;
    if (cnt_obs[0] !== 16'd1) begin
      n_fail++;
      $display("FAIL lat1_cnt: got %0d want 1", cnt_obs[0]);
    end
    n_checks++;
    if (ctl[1] !== 4'b1100) begin
      n_fail++;
      $display("FAIL lat3_still_stall_c2: got %b want 1100", ctl[1]);
    end
    idle();
  endtask

  task automatic test_mem_freeze();
    logic [3:0] want [6] = '{4'b0000, 4'b1100, 4'b0001, 4'b1100, 4'b1100, 4'b0000};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      step();
      if (c == 0) drive(1'b1, 4'd1, 1'b0, 4'd2, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0);
      else drive(1'b1, 4'd3, 1'b1, 4'd5, 1'b1, 4'd4, 1'b0, 1'b0, c == 2);
      #1;
      n_checks++;
      if (ctl[1] !== want[c]) begin
        n_fail++;
        $display("FAIL freeze_seq_c%0d: got %b want %b", c, ctl[1], want[c]);
      end
    end
    n_checks++;
    if (cnt_obs[1] !== 16'd3) begin
      n_fail++;
      $display("FAIL freeze_cnt: got %0d want 3", cnt_obs[1]);
    end
    idle();
  endtask

  task automatic test_zero_reg();
    do_reset();
    step();
    drive(1'b1, 4'd1, 1'b0, 4'd2, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);  // LW R0
    step();
    drive(1'b1, 4'd0, 1'b1, 4'd7, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (ctl[0] !== 4'b0000 || ctl[1] !== 4'b0000) begin
      n_fail++;
      $display("FAIL zero_reg_nostall: got %b/%b want 0000/0000", ctl[0], ctl[1]);
    end
    n_checks++;
    if (ctl[2] !== 4'b1100) begin
      n_fail++;
      $display("FAIL zero_reg_off_stall: got %b want 1100", ctl[2]);
    end
    idle();
  endtask

  task automatic test_branch_priority();
    do_reset();
    step();
    drive(1'b1, 4'd1, 1'b0, 4'd2, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 4'd3, 1'b1, 4'd5, 1'b1, 4'd4, 1'b0, 1'b1, 1'b0);
    #1;
    n_checks++;
    if (ctl[0] !== 4'b0110 || ctl[1] !== 4'b0110) begin
      n_fail++;
      $display("FAIL branch_flush: got %b/%b want 0110/0110", ctl[0], ctl[1]);
    end
    step();
    br = 1'b0;
    #1;
    n_checks++;
    if (cnt_obs[0] !== 16'd0 || cnt_obs[1] !== 16'd0) begin
      n_fail++;
      $display("FAIL branch_cnt: got %0d/%0d want 0/0", cnt_obs[0], cnt_obs[1]);
    end
    n_checks++;
    if (ctl[0] !== 4'b0000 || ctl[1] !== 4'b1100) begin
      n_fail++;
      $display("FAIL branch_after: got %b/%b want 0000/1100", ctl[0], ctl[1]);
    end
    idle();
  endtask

  task automatic test_async_reset();
    do_reset();
    step();
    drive(1'b1, 4'd1, 1'b0, 4'd1, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0);  // LW R2
    step();
    drive(1'b1, 4'd2, 1'b1, 4'd9, 1'b1, 4'd8, 1'b0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (stall_o !== 3'b111) begin
      n_fail++;
      $display("FAIL arst_pre_stall: got %b want 111", stall_o);
    end
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (ctl[k] !== 4'b0000) begin
        n_fail++;
        $display("FAIL arst_outputs[%0d]: got %b want 0000", k, ctl[k]);
      end
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (stall_o !== 3'b000 || bubble_o !== 3'b000) begin
      n_fail++;
      $display("FAIL arst_reader: got %b/%b want 000/000", stall_o, bubble_o);
    end
    idle();
  endtask

  task automatic test_saturation();
    int unsigned exp_cnt = 0;
    do_reset();
    for (int b = 0; b < 3; b++) begin
      step();
      drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0);  // LW R5
      for (int c = 0; c < 8; c++) begin
        step();
        drive(1'b1, 4'd5, 1'b1, 4'd0, 1'b0, 4'd6, 1'b0, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (stall_o[2] !== (c < 7) || cnt_obs[2] !== 16'(exp_cnt)) begin
          n_fail++;
          $display("FAIL sat_b%0d_c%0d: got stall=%b cnt=%0d want stall=%b cnt=%0d",
                   b, c, stall_o[2], cnt_obs[2], c < 7, exp_cnt);
        end
        if (c < 7 && exp_cnt < 15) exp_cnt++;
      end
    end
    step();
    #1;
    n_checks++;
    if (cnt_obs[2] !== 16'd15) begin
      n_fail++;
      $display("FAIL sat_final: got %0d want 15", cnt_obs[2]);
    end
    idle();
  endtask

  task automatic test_random(input int n);
    logic [3:0] exp_ctl;
    bit h [3];
    do_reset();
    model_clear();
    act = 0;
    for (int i = 0; i < n; i++) begin
      step();
      drive($urandom_range(0, 9) < 8, 4'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 4)),
            $urandom_range(0, 9) < 4, $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 2);
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
          n_checks++;
          if (ctl[k] !== 4'b0000 || cnt_obs[k] !== 16'd0) begin
            n_fail++;
            $display("FAIL rand_rst[%0d] i=%0d: got %b cnt=%0d want 0000 cnt=0",
                     k, i, ctl[k], cnt_obs[k]);
          end
        end
        rst = 1'b0;
        model_clear();
      end
      #1;
      for (int k = 0; k < 3; k++) begin
        h[k] = valid && ((u1 && pending(k, src1)) || (u2 && pending(k, src2)));
        exp_ctl = busy ? 4'b0001 : br ? 4'b0110 : h[k] ? 4'b1100 : 4'b0000;
        n_checks++;
        if (ctl[k] !== exp_ctl || cnt_obs[k] !== 16'(mcnt[k])) begin
          n_fail++;
          $display("FAIL rand[%0d] i=%0d: got %b cnt=%0d want %b cnt=%0d",
                   k, i, ctl[k], cnt_obs[k], exp_ctl, mcnt[k]);
        end
      end
      for (int k = 0; k < 3; k++) begin
        if (!busy && !br && h[k] && mcnt[k] < cmax[k]) mcnt[k]++;
        if (valid && !busy && !br && !h[k] && load && !(zr[k] != 0 && dst == 4'd0))
          avail_at[k][dst] = act + 1 + lat[k];
      end
      if (!busy) act++;
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_load_use_lat1();
    test_mem_freeze();
    test_zero_reg();
    test_branch_priority();
    test_async_reset();
    test_saturation();
    test_random(600);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
